// File: rtl/ips2l_uart_cmd_master_32bit.sv
// ips2l_uart_cmd_master_32bit
//
// Turns UART byte frames into single register transactions on the 32-bit
// version/control register block and sends the response back over UART.
//
//   Write frame : A5 addr d3 d2 d1 d0   -> response 06 (ACK)
//   Read frame  : 5A addr               -> response fifo_data, MSB first
//   No completion within CMD_TIMEOUT    -> response 15 (NAK)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   tx_data/tx_valid  response byte and pending flag; tx_ready accepts it
//   addr/data/we      transaction fields, held from cmd_en to completion
//   cmd_en            one-cycle transaction start pulse
//   cmd_done          completion pulse from the register block
//   fifo_data         read data, valid while fifo_data_req is high
//   fifo_data_valid   read-data sink ready (waiting on a read)
//   busy              high whenever a frame or transaction is in progress
//   rx_drop           pulse when a byte arrives while a transaction is active
module ips2l_uart_cmd_master_32bit #(
  parameter logic [23:0] CMD_TIMEOUT  = 24'd1024,
  parameter logic [23:0] BYTE_TIMEOUT = 24'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  addr,
  output logic [31:0] data,
  output logic        we,
  output logic        cmd_en,
  input  logic        cmd_done,
  input  logic [31:0] fifo_data,
  output logic        fifo_data_valid,
  input  logic        fifo_data_req,
  output logic        busy,
  output logic        rx_drop
);

  localparam logic [7:0] SOF_WR = 8'hA5;
  localparam logic [7:0] SOF_RD = 8'h5A;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    ISSUE,
    WAIT_DONE,
    SEND
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  addr_reg, addr_next;
  logic [31:0] data_reg, data_next;
  logic        we_reg, we_next;
  logic        cmd_en_reg, cmd_en_next;
  logic        fdv_reg, fdv_next;
  logic        busy_reg, busy_next;
  logic        rx_drop_reg, rx_drop_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic        tx_valid_reg, tx_valid_next;
  logic [23:0] gap_reg, gap_next;          // idle cycles between frame bytes
  logic [23:0] cmd_cnt_reg, cmd_cnt_next;  // cycles spent in WAIT_DONE
  logic [1:0]  byte_cnt_reg, byte_cnt_next;
  logic [31:0] resp_reg, resp_next;        // response bytes still to send, MSB first
  logic [1:0]  left_reg, left_next;        // bytes remaining after the one on tx_data
  logic [31:0] rd_hold_reg, rd_hold_next;  // fifo_data captured on fifo_data_req
  logic [31:0] rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= 8'd0;
      data_reg     <= 32'd0;
      we_reg       <= 1'b0;
      cmd_en_reg   <= 1'b0;
      fdv_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      rx_drop_reg  <= 1'b0;
      tx_data_reg  <= 8'd0;
      tx_valid_reg <= 1'b0;
      gap_reg      <= 24'd0;
      cmd_cnt_reg  <= 24'd0;
      byte_cnt_reg <= 2'd0;
      resp_reg     <= 32'd0;
      left_reg     <= 2'd0;
      rd_hold_reg  <= 32'd0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      we_reg       <= we_next;
      cmd_en_reg   <= cmd_en_next;
      fdv_reg      <= fdv_next;
      busy_reg     <= busy_next;
      rx_drop_reg  <= rx_drop_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      gap_reg      <= gap_next;
      cmd_cnt_reg  <= cmd_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      resp_reg     <= resp_next;
      left_reg     <= left_next;
      rd_hold_reg  <= rd_hold_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    we_next       = we_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    gap_next      = gap_reg;
    cmd_cnt_next  = cmd_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    resp_next     = resp_reg;
    left_next     = left_reg;
    rd_hold_next  = rd_hold_reg;
    rx_drop_next  = 1'b0;
    rd_word       = 32'd0;

    case (state_reg)
      IDLE: begin
        // Unknown start bytes are skipped silently so the parser resyncs.
        if (rx_valid && (rx_data == SOF_WR || rx_data == SOF_RD)) begin
          we_next    = (rx_data == SOF_WR);
          gap_next   = 24'd0;
          state_next = GET_ADDR;
        end
      end

      GET_ADDR: begin
        // A byte arriving in the expiry cycle still wins over the timeout.
        if (rx_valid) begin
          addr_next     = rx_data;
          gap_next      = 24'd0;
          byte_cnt_next = 2'd0;
          state_next    = we_reg ? GET_DATA : ISSUE;
        end else if (gap_reg == BYTE_TIMEOUT - 24'd1) begin
          state_next = IDLE;
        end else begin
          gap_next = gap_reg + 24'd1;
        end
      end

      GET_DATA: begin
        if (rx_valid) begin
          data_next     = {data_reg[23:0], rx_data};
          gap_next      = 24'd0;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            state_next = ISSUE;
          end
        end else if (gap_reg == BYTE_TIMEOUT - 24'd1) begin
          state_next = IDLE;
        end else begin
          gap_next = gap_reg + 24'd1;
        end
      end

      ISSUE: begin
        rx_drop_next = rx_valid;
        cmd_cnt_next = 24'd0;
        state_next   = WAIT_DONE;
      end

      WAIT_DONE: begin
        rx_drop_next = rx_valid;
        cmd_cnt_next = cmd_cnt_reg + 24'd1;
        if (fifo_data_req) begin
          rd_hold_next = fifo_data;
        end
        // Completion takes priority over a timeout expiring in the same cycle.
        if (cmd_done) begin
          tx_valid_next = 1'b1;
          state_next    = SEND;
          if (we_reg) begin
            tx_data_next = ACK;
            left_next    = 2'd0;
          end else begin
            rd_word      = fifo_data_req ? fifo_data : rd_hold_reg;
            tx_data_next = rd_word[31:24];
            resp_next    = {rd_word[23:0], 8'h00};
            left_next    = 2'd3;
          end
        end else if (cmd_cnt_reg == CMD_TIMEOUT - 24'd1) begin
          tx_valid_next = 1'b1;
          tx_data_next  = NAK;
          left_next     = 2'd0;
          state_next    = SEND;
        end
      end

      SEND: begin
        rx_drop_next = rx_valid;
        if (tx_ready) begin
          if (left_reg == 2'd0) begin
            tx_valid_next = 1'b0;
            state_next    = IDLE;
          end else begin
            tx_data_next = resp_reg[31:24];
            resp_next    = {resp_reg[23:0], 8'h00};
            left_next    = left_reg - 2'd1;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    // Status outputs are registered copies of what the next state implies.
    cmd_en_next = (state_next == ISSUE);
    fdv_next    = (state_next == WAIT_DONE) && !we_next;
    busy_next   = (state_next != IDLE);
  end

  assign addr            = addr_reg;
  assign data            = data_reg;
  assign we              = we_reg;
  assign cmd_en          = cmd_en_reg;
  assign fifo_data_valid = fdv_reg;
  assign busy            = busy_reg;
  assign rx_drop         = rx_drop_reg;
  assign tx_data         = tx_data_reg;
  assign tx_valid        = tx_valid_reg;

endmodule

// File: doc/ips2l_uart_cmd_master_32bit.md
# ips2l_uart_cmd_master_32bit

Command master for the 32-bit UART control path. It parses byte frames from the UART receiver into single register write or read transactions. It drives them onto the addr/data/we/cmd_en/cmd_done bus of the 32-bit version/control register block, captures read data from that block's fifo_data/fifo_data_req output, and serialises the response back to the UART transmitter.

## Interface

Parameters:
- CMD_TIMEOUT, 24'd1024: cycles allowed in WAIT_DONE before a NAK is sent.
- BYTE_TIMEOUT, 24'd100000: maximum gap between frame bytes before the frame is abandoned.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- rx_data, input, 8: received UART byte.
- rx_valid, input, 1: one-cycle strobe; rx_data is valid.
- tx_data, output, 8: response byte.
- tx_valid, output, 1: response byte pending.
- tx_ready, input, 1: transmitter accepts tx_data when tx_valid && tx_ready.
- addr, output, 8: register address; stable from cmd_en until cmd_done or timeout.
- data, output, 32: write data; stable over the same window.
- we, output, 1: 1 = write, 0 = read; stable over the same window.
- cmd_en, output, 1: one-cycle transaction start pulse.
- cmd_done, input, 1: transaction complete pulse from the register block.
- fifo_data, input, 32: read data from the register block.
- fifo_data_valid, output, 1: read-data sink ready; high only in WAIT_DONE of a read.
- fifo_data_req, input, 1: fifo_data is valid this cycle.
- busy, output, 1: high in every state except IDLE.
- rx_drop, output, 1: one-cycle pulse when an rx byte is discarded outside IDLE/GET_ADDR/GET_DATA.

## Operation

Frame format:
- Write frame: 0xA5, addr, d[31:24], d[23:16], d[15:8], d[7:0].
- Read frame: 0x5A, addr.
- Write response: single byte 0x06 (ACK).
- Read response: fifo_data as 4 bytes, MSB first.
- Timeout response: single byte 0x15 (NAK).

States:
- IDLE: rx_valid with 0xA5 loads we=1 and goes to GET_ADDR. 0x5A loads we=0 and goes to GET_ADDR. Any other byte is ignored silently, with no rx_drop pulse.
- GET_ADDR: rx byte is loaded into addr. Next state is GET_DATA for a write, ISSUE for a read.
- GET_DATA: 4 bytes are shifted into data, MSB first; byte counter runs 0..3. After the 4th byte the next state is ISSUE.
- ISSUE: cmd_en=1 for exactly one cycle, then WAIT_DONE. The timeout counter is cleared.
- WAIT_DONE: counter increments each cycle.
  - cmd_done on a write: response = ACK.
  - cmd_done on a read: response = fifo_data, latched in the cycle fifo_data_req is high. fifo_data_req and cmd_done arrive in the same cycle.
  - Counter reaches CMD_TIMEOUT-1 with no cmd_done: response = NAK.
  - All three cases go to SEND.
- SEND: tx_valid=1 with the current byte. The byte index advances on tx_valid && tx_ready. After the last byte is accepted, tx_valid drops and the state returns to IDLE.

Boundary rules:
- Byte timeout: in GET_ADDR/GET_DATA, the gap counter resets on every rx_valid. When it reaches BYTE_TIMEOUT-1, the frame is abandoned and the state returns to IDLE with no cmd_en and no response.
- Discarded bytes: rx_valid in ISSUE, WAIT_DONE or SEND discards the byte and pulses rx_drop.
- Simultaneous events: rx_valid in the cycle the byte timeout expires accepts the byte and restarts the count. cmd_done in the cycle CMD_TIMEOUT expires is treated as completion, not NAK.
- Late completion: cmd_done or fifo_data_req outside WAIT_DONE is ignored.
- Reset: reset mid-frame or mid-SEND returns to IDLE immediately. A partially sent response is not resumed.

## Timing

- Reset values: addr=0, data=0, we=0, cmd_en=0, fifo_data_valid=0, tx_valid=0, tx_data=0, busy=0, rx_drop=0.
- All outputs are registered.
- cmd_en asserts 1 cycle after the rx_valid of the last frame byte.
- tx_valid asserts 1 cycle after cmd_done, or 1 cycle after the CMD_TIMEOUT expiry cycle.
- Back-to-back bytes: with tx_ready held high, one byte is sent per cycle.
- Backpressure: tx_data and tx_valid hold unchanged while tx_ready=0.
- The register block completes a write ≤4 cycles after cmd_en. Read completion latency depends on the clock-domain crossing and is bounded only by CMD_TIMEOUT.
- First new frame byte: accepted in the cycle after the last response byte handshake.

## Test plan

- Write: rx A5 03 12 34 56 78 -> one cmd_en pulse with addr=0x03, data=0x12345678, we=1. Model returns cmd_done 3 cycles later -> tx byte 0x06, busy low afterwards.
- Read: rx 5A FF, with the model returning cmd_done+fifo_data_req and fifo_data=0x20200729 -> fifo_data_valid high during the wait; tx bytes 20 20 07 29 in order.
- Garbage then valid: rx 00 3C, then 5A 01 -> only one cmd_en (read, addr=0x01), no rx_drop pulse.
- Truncated frame: rx A5 02 11, then silence for BYTE_TIMEOUT cycles -> no cmd_en, busy low. A following 5A 02 issues a read normally.
- Silent responder: rx 5A 05, with cmd_done never asserted -> tx byte 0x15 exactly CMD_TIMEOUT+1 cycles after cmd_en. A late cmd_done is ignored.
- Backpressure and reset: during a read response, hold tx_ready low 10 cycles -> tx_data stable. Then assert rst_n low mid-SEND -> all outputs return to their reset values and the state is IDLE.
